mtr_drv: RTL and testbench

- Power-stage driver directly downstream of the commutation block.
- Consumes 11-bit duty and the per-phase 2-bit selects (selGrn/selYlw/selBlu). Produces the six gate drives for the three-phase inverter.
- Generates the 11-bit PWM carrier and the PWM_synch strobe that is fed back upstream to the hall-sampling logic.
- Inserts programmable dead time on every high/low pair so both FETs of one leg are never on together.

---
 rtl/mtr_drv.sv | 138 +++++++++++++
 tb/tb_mtr_drv.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv.sv
// Three-phase gate driver: PWM carrier, per-leg request decode, dead-time insertion.
// Optional shoot-through monitor enabled by defining MTR_DRV_SHOOT_CHK_EN.
module mtr_drv #(
    parameter int DEADTIME = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] duty,
    input  logic [1:0]  selGrn,
    input  logic [1:0]  selYlw,
    input  logic [1:0]  selBlu,
    output logic        PWM_synch,
    output logic        highGrn,
    output logic        lowGrn,
    output logic        highYlw,
    output logic        lowYlw,
    output logic        highBlu,
    output logic        lowBlu,
    output logic        shoot_flt
);

    typedef enum logic {PASS, DEAD} leg_st_t;

    localparam logic [7:0] DT_LAST = 8'(DEADTIME - 1);

    logic [10:0]     cnt;
    logic [10:0]     cnt_nxt;
    logic [10:0]     duty_lat;
    logic [10:0]     duty_nxt;
    logic            pwm_sig;
    logic [2:0][1:0] sel;
    logic [2:0]      high_raw;
    logic [2:0]      low_raw;

    function automatic logic [1:0] leg_req(input logic [1:0] s, input logic p);
        logic [1:0] r;
        unique case (s)
            2'b00:   r = 2'b00;
            2'b01:   r = {~p, p};
            2'b10:   r = {p, ~p};
            default: r = {1'b0, p};
        endcase
        return r;
    endfunction

    assign cnt_nxt  = cnt + 11'd1;
    // New duty is visible to the compare on the same edge the counter wraps.
    assign duty_nxt = (cnt == 11'h7ff) ? duty : duty_lat;
    assign sel      = {selBlu, selYlw, selGrn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            duty_lat  <= '0;
            pwm_sig   <= 1'b0;
            PWM_synch <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            duty_lat  <= duty_nxt;
            pwm_sig   <= cnt_nxt < duty_nxt;
            PWM_synch <= cnt == 11'd1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_leg
        leg_st_t    st;
        logic       prev_h;
        logic       prev_l;
        logic [7:0] dt_cnt;
        logic       hreq;
        logic       lreq;
        logic       chg;
        logic       h_q;
        logic       l_q;

        assign {hreq, lreq} = leg_req(sel[g], pwm_sig);
        assign chg          = (hreq != prev_h) || (lreq != prev_l);
        assign high_raw[g]  = h_q;
        assign low_raw[g]   = l_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st     <= PASS;
                prev_h <= 1'b0;
                prev_l <= 1'b0;
                dt_cnt <= '0;
                h_q    <= 1'b0;
                l_q    <= 1'b0;
            end else begin
                prev_h <= hreq;
                prev_l <= lreq;
                unique case (st)
                    PASS: begin
                        if (chg) begin
                            st     <= DEAD;
                            dt_cnt <= '0;
                            h_q    <= 1'b0;
                            l_q    <= 1'b0;
                        end else begin
                            h_q <= hreq;
                            l_q <= lreq;
                        end
                    end
                    DEAD: begin
                        h_q <= 1'b0;
                        l_q <= 1'b0;
                        if (chg) begin
                            dt_cnt <= '0;
                        end else if (dt_cnt == DT_LAST) begin
                            st  <= PASS;
                            h_q <= hreq;
                            l_q <= lreq;
                        end else begin
                            dt_cnt <= dt_cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef MTR_DRV_SHOOT_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shoot_flt <= 1'b0;
        else if (|(high_raw & low_raw))
            shoot_flt <= 1'b1;
    end

    assign {highBlu, highYlw, highGrn} = high_raw & ~{3{shoot_flt}};
    assign {lowBlu, lowYlw, lowGrn}    = low_raw & ~{3{shoot_flt}};
`else
    assign shoot_flt                   = 1'b0;
    assign {highBlu, highYlw, highGrn} = high_raw;
    assign {lowBlu, lowYlw, lowGrn}    = low_raw;
`endif

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: per-cycle reference model, steady-state
// vector table, and hand sequences for dead-time, duty latch and reset.
module tb_mtr_drv;

    localparam int DT  = 32;
    localparam int PER = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] duty = '0;
    logic [1:0]  sel_g = '0;
    logic [1:0]  sel_y = '0;
    logic [1:0]  sel_b = '0;
    logic        PWM_synch;
    logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu;
    logic        shoot_flt;

    always #5 clk = ~clk;

    mtr_drv #(.DEADTIME(DT)) dut (
        .clk(clk), .rst_n(rst_n), .duty(duty),
        .selGrn(sel_g), .selYlw(sel_y), .selBlu(sel_b),
        .PWM_synch(PWM_synch),
        .highGrn(highGrn), .lowGrn(lowGrn),
        .highYlw(highYlw), .lowYlw(lowYlw),
        .highBlu(highBlu), .lowBlu(lowBlu),
        .shoot_flt(shoot_flt)
    );

    int errors = 0;
    int checks = 0;

    // Reference: carrier position/duty as integers, legs as request history
    // plus the cycle index of the last request change.
    int       m_pos, m_duty, k, last_sync;
    bit       m_pwm, m_sync;
    int       last_chg [3];
    bit [1:0] prev_req [3];
    bit [1:0] m_out [3];

    typedef struct {
        logic [10:0] duty;
        logic [1:0]  sel;
        int          exp_hi;
        int          exp_lo;
    } vec_t;

    vec_t tbl [8];

    function automatic bit [1:0] req_of(input bit [1:0] s, input bit p);
        case (s)
            2'b00:   return 2'b00;
            2'b01:   return {~p, p};
            2'b10:   return {p, ~p};
            default: return {1'b0, p};
        endcase
    endfunction

    function automatic bit [1:0] sel_of(input int i);
        if (i == 0) return sel_g;
        if (i == 1) return sel_y;
        return sel_b;
    endfunction

    function automatic logic [7:0] got_vec();
        return {PWM_synch, highGrn, lowGrn, highYlw, lowYlw,
                highBlu, lowBlu, shoot_flt};
    endfunction

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_duty = 0; m_pwm = 0; m_sync = 0; k = 0;
        last_sync = -1;
        for (int i = 0; i < 3; i++) begin
            last_chg[i] = -100000;
            prev_req[i] = 2'b00;
            m_out[i]    = 2'b00;
        end
    endtask

    task automatic model_edge();
        bit [1:0] r;
        for (int i = 0; i < 3; i++) begin
            r = req_of(sel_of(i), m_pwm);
            if (r != prev_req[i]) last_chg[i] = k;
            prev_req[i] = r;
            m_out[i] = (k - last_chg[i] >= DT) ? r : 2'b00;
        end
        m_sync = (m_pos == 1);
        if (m_pos == PER - 1) m_duty = int'(duty);
        m_pos = (m_pos + 1) % PER;
        m_pwm = m_pos < m_duty;
        k++;
    endtask

    task automatic tick();
        logic [7:0] exp;
        model_edge();
        @(posedge clk);
        #1;
        exp = {m_sync, m_out[0], m_out[1], m_out[2], 1'b0};
        checks++;
        if (got_vec() !== exp) begin
            errors++;
            $display("FAIL cycle k=%0d got=%b exp=%b", k, got_vec(), exp);
        end
        if (PWM_synch === 1'b1) begin
            if (last_sync >= 0) check_eq("sync_gap", k - last_sync, PER);
            last_sync = k;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 2 * PER && m_pos != p; i++) tick();
    endtask

    initial begin
        int hi, lo, other, run, rmin, rmax, nruns, zeros;

        tbl[0] = '{11'd0,    2'b10, 0,    2048};
        tbl[1] = '{11'd1024, 2'b10, 992,  992};
        tbl[2] = '{11'd600,  2'b01, 1416, 568};
        tbl[3] = '{11'd1500, 2'b11, 0,    1468};
        tbl[4] = '{11'd2047, 2'b11, 0,    2015};
        tbl[5] = '{11'd20,   2'b10, 0,    1996};
        tbl[6] = '{11'd2047, 2'b10, 2015, 0};
        tbl[7] = '{11'd700,  2'b00, 0,    0};

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", int'(got_vec()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Idle: nothing may switch, sync keeps its period.
        other = 0;
        for (int i = 0; i < 2 * PER + 100; i++) begin
            tick();
            other += int'(got_vec()[6:1] != 0);
        end
        check_eq("idle_gates", other, 0);

        for (int v = 0; v < 8; v++) begin
            duty  = tbl[v].duty;
            sel_g = tbl[v].sel;
            ticks(PER + 52);
            hi = 0; lo = 0; other = 0;
            for (int i = 0; i < PER; i++) begin
                tick();
                hi    += int'(highGrn);
                lo    += int'(lowGrn);
                other += int'(highYlw | lowYlw | highBlu | lowBlu);
            end
            check_eq($sformatf("tbl%0d_high", v), hi, tbl[v].exp_hi);
            check_eq($sformatf("tbl%0d_low", v), lo, tbl[v].exp_lo);
            check_eq($sformatf("tbl%0d_others", v), other, 0);
        end

        // Both-off gaps at 50% forward drive.
        duty = 11'd1024; sel_g = 2'b10;
        ticks(PER + 52);
        wait_pos(0);
        run = 0; rmin = 9999; rmax = 0; nruns = 0;
        for (int i = 0; i < PER; i++) begin
            tick();
            if (!highGrn && !lowGrn) begin
                run++;
            end else if (run > 0) begin
                nruns++;
                if (run < rmin) rmin = run;
                if (run > rmax) rmax = run;
                run = 0;
            end
        end
        check_eq("gap_count", nruns, 2);
        check_eq("gap_min", rmin, DT);
        check_eq("gap_max", rmax, DT);

        // Duty change mid-period only lands after the wrap.
        duty = 11'd512;
        ticks(PER + 52);
        wait_pos(1000);
        duty = 11'd1536;
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            tick();
            if (m_pos == 0) break;
            hi += int'(highGrn);
        end
        check_eq("old_period_tail_high", hi, 0);
        hi = int'(highGrn);
        for (int i = 0; i < PER - 1; i++) begin
            tick();
            hi += int'(highGrn);
        end
        check_eq("new_period_high", hi, 1504);

        // Fast toggling holds the yellow leg off.
        sel_g = 2'b00; sel_y = 2'b10;
        wait_pos(100);
        other = 0;
        for (int t = 0; t < 20; t++) begin
            sel_y = (sel_y == 2'b10) ? 2'b01 : 2'b10;
            for (int i = 0; i < 10; i++) begin
                tick();
                other += int'(highYlw | lowYlw);
            end
        end
        check_eq("toggle_off", other, 0);
        sel_y = (sel_y == 2'b10) ? 2'b01 : 2'b10;
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (highYlw || lowYlw) break;
            zeros++;
        end
        check_eq("toggle_resume", zeros, DT);

        // Async reset with a gate on.
        sel_y = 2'b00; sel_g = 2'b10; duty = 11'd1024;
        ticks(PER + 52);
        wait_pos(500);
        check_eq("pre_reset_high", int'(highGrn), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", int'(got_vec()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        check_eq("sync_after_1", int'(PWM_synch), 0);
        tick();
        check_eq("sync_after_2", int'(PWM_synch), 1);

        // Random drive against the model.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 2))
                    0:       sel_g = 2'($urandom_range(0, 3));
                    1:       sel_y = 2'($urandom_range(0, 3));
                    default: sel_b = 2'($urandom_range(0, 3));
                endcase
            end
            if ($urandom_range(0, 999) < 2) duty = 11'($urandom_range(0, 2047));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
